// File: rtl/hazard_unit_pkg.sv
// Shared pipeline encodings for the 5-stage RISC-V core.
// Also holds the operand-forwarding priority rule used by the hazard unit.
package hazard_unit_pkg;

    typedef logic [4:0] regIdx_t;

    localparam regIdx_t REG_X0 = 5'd0;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    function automatic logic [1:0] fwdSel(
        input regIdx_t rsE,
        input regIdx_t rdM,
        input logic    regWriteM,
        input regIdx_t rdW,
        input logic    regWriteW
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regWriteM && (rdM != REG_X0) && (rdM == rsE)) begin
            sel = FWD_MEM;
        end else if (regWriteW && (rdW != REG_X0) && (rdW == rsE)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// A synchronous clear takes precedence over an increment in the same cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: forwarding
// selects, load-use stall, redirect flush, event counters and a stall watchdog.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResSrcE,
    input  logic             PcSrcE,
    input  logic             CntClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic             HazardErr
);

    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

    localparam logic [0:0] ST_OK  = 1'b0;
    localparam logic [0:0] ST_ERR = 1'b1;

    logic             lwStall;
    logic [0:0]       state;
    logic [RUN_W-1:0] runLen;

    // Reset forces a bubble into ID/EX and IF/ID so the pipeline restarts clean.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        lwStall   = (ResSrcE == RES_LOAD) && (RdE != REG_X0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
        if (!Rst) begin
            ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            StallF    = lwStall && !PcSrcE;
            StallD    = lwStall && !PcSrcE;
            FlushD    = PcSrcE;
            FlushE    = lwStall || PcSrcE;
        end
    end

    sat_counter #(.W(CNT_W)) stallCounter (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (StallD),
        .clr   (CntClr),
        .count (StallCnt)
    );

    sat_counter #(.W(CNT_W)) flushCounter (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (PcSrcE),
        .clr   (CntClr),
        .count (FlushCnt)
    );

    // Watchdog: one stall past MAX_STALL consecutive cycles latches ERR until reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= ST_OK;
            runLen <= '0;
        end else begin
            case (state)
                ST_OK: begin
                    if (StallD) begin
                        if (runLen == RUN_LIMIT) begin
                            state  <= ST_ERR;
                            runLen <= '0;
                        end else begin
                            runLen <= runLen + 1'b1;
                        end
                    end else begin
                        runLen <= '0;
                    end
                end
                default: begin
                    state  <= ST_ERR;
                    runLen <= '0;
                end
            endcase
        end
    end

    assign HazardErr = (state == ST_ERR);

endmodule
